// File: rtl/dmaster_packets_to_bytes_if.sv
// Bundle of the beat-side and byte-side handshakes of the packets-to-bytes serialiser.
// The master modport is the bench/upstream view; the slave modport is the serialiser's view.
interface dmaster_packets_to_bytes_if #(
  parameter int CHANNEL_W = 8
);
  logic                 in_ready;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_startofpacket;
  logic                 in_endofpacket;
  logic [CHANNEL_W-1:0] in_channel;
  logic                 out_ready;
  logic                 out_valid;
  logic [7:0]           out_data;

  modport master (
    input  in_ready, out_valid, out_data,
    output in_valid, in_data, in_startofpacket, in_endofpacket, in_channel, out_ready
  );

  modport slave (
    output in_ready, out_valid, out_data,
    input  in_valid, in_data, in_startofpacket, in_endofpacket, in_channel, out_ready
  );
endinterface

// File: rtl/dmaster_packets_to_bytes.sv
// Serialises Avalon-ST beats into a byte stream with inline SOP/EOP/CHANNEL/ESCAPE codes.
// Define DMASTER_P2B_CHANNEL_EN to emit channel-change items (0x7C + channel byte).
module dmaster_packets_to_bytes #(
  parameter int CHANNEL_W = 8
) (
  input logic                     clk,
  input logic                     reset_n,
  dmaster_packets_to_bytes_if.slave bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHAN_BYTE = 3'd1;
  localparam logic [2:0] ST_CHAN_ESC  = 3'd2;
  localparam logic [2:0] ST_SOP       = 3'd3;
  localparam logic [2:0] ST_EOP       = 3'd4;
  localparam logic [2:0] ST_DATA_ESC  = 3'd5;

  localparam logic [7:0] CODE_SOP  = 8'h7A;
  localparam logic [7:0] CODE_EOP  = 8'h7B;
  localparam logic [7:0] CODE_CHAN = 8'h7C;
  localparam logic [7:0] CODE_ESC  = 8'h7D;

  function automatic logic is_special(input logic [7:0] b);
    return (b >= CODE_SOP) && (b <= CODE_ESC);
  endfunction

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] byte_out;
  logic       last_byte;
  logic       fire;
  logic       data_esc;
  logic [7:0] data_first;

  assign fire       = bus.out_valid && bus.out_ready;
  assign data_esc   = is_special(bus.in_data);
  assign data_first = data_esc ? CODE_ESC : bus.in_data;

`ifdef DMASTER_P2B_CHANNEL_EN
  logic [CHANNEL_W-1:0] last_chan;
  logic                 chan_known;
  logic                 need_chan;
  logic                 chan_sent;
  logic [7:0]           chan_byte;

  assign chan_byte = 8'(bus.in_channel);
  assign need_chan = !chan_known || (bus.in_channel != last_chan);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_chan  <= '0;
      chan_known <= 1'b0;
    end else if (fire && chan_sent) begin
      last_chan  <= bus.in_channel;
      chan_known <= 1'b1;
    end
  end
`endif

  // Once the channel byte goes out the channel matches, so ST_IDLE naturally resumes at SOP.
  always_comb begin
    state_nxt = state;
    byte_out  = data_first;
    last_byte = 1'b0;
`ifdef DMASTER_P2B_CHANNEL_EN
    chan_sent = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
`ifdef DMASTER_P2B_CHANNEL_EN
        if (need_chan) begin
          byte_out  = CODE_CHAN;
          state_nxt = ST_CHAN_BYTE;
        end else
`endif
        if (bus.in_startofpacket) begin
          byte_out  = CODE_SOP;
          state_nxt = ST_SOP;
        end else if (bus.in_endofpacket) begin
          byte_out  = CODE_EOP;
          state_nxt = ST_EOP;
        end else begin
          byte_out  = data_first;
          last_byte = !data_esc;
          state_nxt = data_esc ? ST_DATA_ESC : ST_IDLE;
        end
      end
`ifdef DMASTER_P2B_CHANNEL_EN
      ST_CHAN_BYTE: begin
        if (is_special(chan_byte)) begin
          byte_out  = CODE_ESC;
          state_nxt = ST_CHAN_ESC;
        end else begin
          byte_out  = chan_byte;
          chan_sent = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_CHAN_ESC: begin
        byte_out  = chan_byte ^ 8'h20;
        chan_sent = 1'b1;
        state_nxt = ST_IDLE;
      end
`endif
      ST_SOP: begin
        if (bus.in_endofpacket) begin
          byte_out  = CODE_EOP;
          state_nxt = ST_EOP;
        end else begin
          byte_out  = data_first;
          last_byte = !data_esc;
          state_nxt = data_esc ? ST_DATA_ESC : ST_IDLE;
        end
      end
      ST_EOP: begin
        byte_out  = data_first;
        last_byte = !data_esc;
        state_nxt = data_esc ? ST_DATA_ESC : ST_IDLE;
      end
      ST_DATA_ESC: begin
        byte_out  = bus.in_data ^ 8'h20;
        last_byte = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else if (fire) begin
      state <= state_nxt;
    end
  end

  assign bus.out_valid = bus.in_valid && reset_n;
  assign bus.out_data  = byte_out;
  assign bus.in_ready  = reset_n && bus.out_ready && last_byte;

endmodule

// File: tb/tb_dmaster_packets_to_bytes.sv
// Self-checking bench for dmaster_packets_to_bytes: beat table plus backpressure and mid-beat reset sequences.
module tb_dmaster_packets_to_bytes;

`ifdef DMASTER_P2B_CHANNEL_EN
  localparam bit CHEN = 1'b1;
`else
  localparam bit CHEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  dmaster_packets_to_bytes_if #(.CHANNEL_W(8)) bus ();

  dmaster_packets_to_bytes #(.CHANNEL_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0]  ch;
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    int          chan_n;
    logic [23:0] cb;
    int          body_n;
    logic [39:0] bb;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  logic [7:0] q [$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_bytes(input logic [39:0] v, input int n);
    for (int i = 0; i < n; i++) q.push_back(8'(v >> (8 * (n - 1 - i))));
  endtask

  task automatic drive(input logic [7:0] ch, input logic [7:0] d, input logic sop, input logic eop);
    bus.in_channel       = ch;
    bus.in_data          = d;
    bus.in_startofpacket = sop;
    bus.in_endofpacket   = eop;
    bus.in_valid         = 1'b1;
  endtask

  // Pops and compares every accepted byte until the beat is consumed, then checks cycle count.
  task automatic collect(input string name, input int exp_cycles);
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk({name, "_extra_byte"}, 1, 0);
        else chk({name, "_byte"}, int'(bus.out_data), int'(q.pop_front()));
      end
      if (bus.in_ready) done = 1'b1;
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
    chk({name, "_leftover"}, q.size(), 0);
    chk({name, "_cycles"}, cyc, exp_cycles);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            ch     d     sop   eop   cn cb         bn bb
    vecs[0]  = '{8'h00, 8'h55, 1'b1, 1'b1, 2, 24'h7C00,   3, 40'h7A7B55};
    vecs[1]  = '{8'h00, 8'h01, 1'b1, 1'b0, 0, 24'h0,      2, 40'h7A01};
    vecs[2]  = '{8'h00, 8'h7B, 1'b0, 1'b0, 0, 24'h0,      2, 40'h7D5B};
    vecs[3]  = '{8'h00, 8'h02, 1'b0, 1'b1, 0, 24'h0,      2, 40'h7B02};
    vecs[4]  = '{8'h7D, 8'h10, 1'b1, 1'b0, 3, 24'h7C7D5D, 2, 40'h7A10};
    vecs[5]  = '{8'h7D, 8'h7A, 1'b0, 1'b1, 0, 24'h0,      3, 40'h7B7D5A};
    vecs[6]  = '{8'h01, 8'h33, 1'b1, 1'b1, 2, 24'h7C01,   3, 40'h7A7B33};
    vecs[7]  = '{8'h01, 8'h7C, 1'b0, 1'b0, 0, 24'h0,      2, 40'h7D5C};
    vecs[8]  = '{8'h01, 8'h7D, 1'b0, 1'b0, 0, 24'h0,      2, 40'h7D5D};
    vecs[9]  = '{8'h01, 8'h79, 1'b0, 1'b0, 0, 24'h0,      1, 40'h79};
    vecs[10] = '{8'h01, 8'h7E, 1'b0, 1'b0, 0, 24'h0,      1, 40'h7E};
    vecs[11] = '{8'h7A, 8'h00, 1'b0, 1'b0, 3, 24'h7C7D5A, 1, 40'h00};
    vecs[12] = '{8'h7C, 8'h7D, 1'b1, 1'b1, 3, 24'h7C7D5C, 4, 40'h7A7B7D5D};

    reset_n       = 1'b0;
    bus.out_ready = 1'b1;
    drive(8'h00, 8'h55, 1'b1, 1'b1);
    #12;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_in_ready", int'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ch, vecs[i].d, vecs[i].sop, vecs[i].eop);
      if (CHEN) push_bytes({16'h0, vecs[i].cb}, vecs[i].chan_n);
      push_bytes(vecs[i].bb, vecs[i].body_n);
      collect($sformatf("vec%0d", i), (CHEN ? vecs[i].chan_n : 0) + vecs[i].body_n);
    end

    // Backpressure: 0x7A presented while sink stalls, nothing consumed.
    drive(8'h7C, 8'h44, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_out_data", int'(bus.out_data), 8'h7A);
      chk("stall_out_valid", int'(bus.out_valid), 1);
      chk("stall_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push_bytes(40'h7A44, 2);
    collect("stall", 2);

    // Reset after the first byte of a beat; the held beat restarts from scratch.
    drive(8'h00, 8'h55, 1'b1, 1'b1);
    @(negedge clk);
    chk("midrst_first", int'(bus.out_data), CHEN ? 8'h7C : 8'h7A);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    if (CHEN) push_bytes(40'h7C00, 2);
    push_bytes(40'h7A7B55, 3);
    collect("midrst", (CHEN ? 2 : 0) + 3);

    bus.in_valid = 1'b0;
    #1;
    chk("idle_out_valid", int'(bus.out_valid), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
